conv4_seq_ctrl: RTL
===================

CONV4_SEQ_CTRL -- requirements
Module: conv4_seq_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-003 SHALL have port: start  input  1  request to convolve the presented operands; sampled only in IDLE.
REQ-004 SHALL have port: x_in  input  16  four unsigned 4-bit samples; x0=[3:0], x1=[7:4], x2=[11:8], x3=[15:12].
REQ-005 SHALL have port: h_in  input  16  four unsigned 4-bit taps; h0=[3:0], h1=[7:4], h2=[11:8], h3=[15:12].
REQ-006 SHALL have port: out_ready  input  1  consumer accepts the current result when high with y_valid.
REQ-007 SHALL have port: busy  output  1  high from the cycle after start is accepted until done.
REQ-008 SHALL have port: y_valid  output  1  y_data and y_idx hold a completed output sample.
REQ-009 SHALL have port: y_idx  output  3  index n of y_data, 0..6.
REQ-010 SHALL have port: y_data  output  10  full-precision sample y[n] = sum over k of x[k]*h[n-k].
REQ-011 SHALL have port: done  output  1  one-cycle pulse after y[6] is accepted.

Function
REQ-012 SHALL compute the 7-point linear convolution of x0..x3 with h0..h3 using exactly one shared 4x4 unsigned multiplier and one 10-bit accumulator.
REQ-013 SHALL use the FSM states IDLE, MAC, EMIT, DONE.
REQ-014 In IDLE with start=1, SHALL register x_in and h_in, set n=0 and k=0, clear acc, and enter MAC next cycle with busy=1.
REQ-015 In IDLE with start=0, SHALL hold all outputs at their reset values.
REQ-016 In MAC, for each output n, SHALL iterate k from max(0,n-3) to min(n,3), one product per cycle, with acc <= acc + x[k]*h[n-k].
REQ-017 Term counts per n SHALL be 1,2,3,4,3,2,1, for 16 MAC cycles per job.
REQ-018 After the last term of n, SHALL enter EMIT next cycle with y_valid=1, y_idx=n, and y_data=acc.
REQ-019 SHALL not truncate: products are 8 bits, sums are 10 bits, and the maximum value 900 fits.
REQ-020 In EMIT, while out_ready=0, SHALL hold y_valid, y_idx and y_data stable.
REQ-021 In EMIT, when out_ready=1 and n<6, SHALL drop y_valid next cycle, clear acc, set n=n+1, and return to MAC.
REQ-022 In EMIT, when out_ready=1 and n=6, SHALL drop y_valid next cycle and enter DONE.
REQ-023 In DONE, SHALL assert done=1 and busy=1 for one cycle, then enter IDLE with busy=0.
REQ-024 With out_ready held at 1, latency SHALL be 23 cycles from the first MAC cycle to the y[6] handshake, plus 1 cycle to done.
REQ-025 SHALL ignore start in all states other than IDLE and SHALL not alter the latched operands mid-job.
REQ-026 SHALL ignore out_ready when y_valid=0.
REQ-027 SHALL not sample start in the DONE cycle; a start in the following IDLE cycle begins a new job.

Reset
REQ-028 When rst_n=0 at a clock edge, SHALL next cycle be in IDLE with busy=0, y_valid=0, y_idx=0, y_data=0, done=0, acc=0, n=0, k=0, and latched operands=0.
REQ-029 Reset SHALL take effect in any state, including mid-MAC and mid-EMIT, and SHALL abandon the job with no done pulse.
REQ-030 SHALL have no asynchronous reset path.

Verification
REQ-031 x=(1,2,3,4), h=(1,1,1,1), out_ready=1 -> y_data sequence 1,3,6,10,9,7,4 with y_idx 0..6, and done 24 cycles after the first MAC cycle.
REQ-032 All x and h = 15 -> 225,450,675,900,675,450,225 with no overflow.
REQ-033 Same operands as REQ-031, out_ready=0 for 5 cycles during y_idx=3 -> y_data=10 held stable, then the sequence resumes unchanged.
REQ-034 start pulsed with new operands while busy -> ignored; outputs match the first job's operands.
REQ-035 rst_n=0 for one cycle during y_idx=2 MAC -> IDLE next cycle, all outputs 0, no done; a new job then completes correctly.
REQ-036 h=(0,0,0,0), any x -> seven results of 0, then a done pulse.

Source files
------------

// File: rtl/conv4_seq_ctrl.sv
// Sequential 4x4-point linear convolution: one shared 4x4 multiplier and one
// accumulator, streaming the seven outputs y[0..6] through a valid/ready handshake.
module conv4_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [15:0] h_in,
    input  logic        out_ready,
    output logic        busy,
    output logic        y_valid,
    output logic [2:0]  y_idx,
    output logic [9:0]  y_data,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] h_q, h_d;
    logic [2:0]  n_q, n_d;
    logic [1:0]  k_q, k_d;
    logic [9:0]  acc_q, acc_d;

    logic [3:0]  x_smp [4];
    logic [3:0]  h_tap [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign x_smp[gi] = x_q[4*gi +: 4];
            assign h_tap[gi] = h_q[4*gi +: 4];
        end
    endgenerate

    // Within MAC, n-k is always in 0..3, so the low two bits select the tap.
    logic [2:0] tap_sel;
    logic [3:0] mul_a, mul_b;
    logic [7:0] product;
    logic [1:0] k_last;
    logic [2:0] n_next;
    logic [2:0] n_next_m3;
    logic [1:0] k_first_next;

    assign tap_sel      = n_q - {1'b0, k_q};
    assign mul_a        = x_smp[k_q];
    assign mul_b        = h_tap[tap_sel[1:0]];
    assign product      = {4'd0, mul_a} * {4'd0, mul_b};
    assign k_last       = (n_q > 3'd3) ? 2'd3 : n_q[1:0];
    assign n_next       = n_q + 3'd1;
    assign n_next_m3    = n_next - 3'd3;
    assign k_first_next = (n_next > 3'd3) ? n_next_m3[1:0] : 2'd0;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        n_d     = n_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    h_d     = h_in;
                    n_d     = 3'd0;
                    k_d     = 2'd0;
                    acc_d   = 10'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + {2'b00, product};
                if (k_q == k_last) begin
                    state_d = EMIT;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (n_q == 3'd6) begin
                        state_d = DONE;
                    end else begin
                        n_d     = n_next;
                        k_d     = k_first_next;
                        acc_d   = 10'd0;
                        state_d = MAC;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            h_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            h_q     <= h_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // Result fields read as zero whenever no sample is being offered.
    assign busy    = (state_q != IDLE);
    assign y_valid = (state_q == EMIT);
    assign done    = (state_q == DONE);
    assign y_idx   = y_valid ? n_q   : 3'd0;
    assign y_data  = y_valid ? acc_q : 10'd0;

endmodule
